// File: rtl/ctl_mc_pkg.sv
// ctl_mc_pkg: shared constants, types and decode helpers for the multi-cycle
// control unit of the Beta-style RISC core.
//   - FSM state encoding (S_*)
//   - Beta opcodes used by name, ALU function codes
//   - pcsel / wdsel codes
//   - is_legal / is_muldiv opcode sets and the single-cycle control-word decode
package ctl_mc_pkg;

   typedef enum logic [1:0] {S_RESET, S_EXEC, S_ALU_WAIT, S_MEM_WAIT} state_e;

   localparam logic [5:0] OP_LD   = 6'h18;
   localparam logic [5:0] OP_ST   = 6'h19;
   localparam logic [5:0] OP_JMP  = 6'h1B;
   localparam logic [5:0] OP_BEQ  = 6'h1C;
   localparam logic [5:0] OP_BNE  = 6'h1D;
   localparam logic [5:0] OP_LDR  = 6'h1F;
   localparam logic [5:0] OP_ADD  = 6'h20;
   localparam logic [5:0] OP_MUL  = 6'h22;
   localparam logic [5:0] OP_DIV  = 6'h23;
   localparam logic [5:0] OP_ADDC = 6'h30;

   // ALU ops and their constant forms share op[3:0], which is used directly as
   // the ALU function (ADD=0, SUB=1, MUL=2, DIV=3, ...). LDR passes operand A.
   localparam logic [5:0] ALU_ADD = 6'h00;
   localparam logic [5:0] ALU_A   = 6'h1A;

   localparam logic [2:0] PCSEL_INC   = 3'd0;
   localparam logic [2:0] PCSEL_BR    = 3'd1;
   localparam logic [2:0] PCSEL_JMP   = 3'd2;
   localparam logic [2:0] PCSEL_ILLOP = 3'd3;
   localparam logic [2:0] PCSEL_XADR  = 3'd4;

   localparam logic [1:0] WDSEL_PC  = 2'd0;
   localparam logic [1:0] WDSEL_ALU = 2'd1;
   localparam logic [1:0] WDSEL_MEM = 2'd2;

   typedef struct packed {
      logic [5:0] alufn;
      logic       asel;
      logic       bsel;
      logic       moe;
      logic       mwr;
      logic [2:0] pcsel;
      logic       ra2sel;
      logic       wasel;
      logic [1:0] wdsel;
      logic       werf;
   } ctl_t;

   // ALU opcodes 0x20-0x3E, excluding the unused low nibbles 7, B and F.
   function automatic logic is_alu_op(input logic [5:0] op);
      return op[5] && (op[3:0] != 4'h7) && (op[3:0] != 4'hB) && (op[3:0] != 4'hF);
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      return is_alu_op(op) || (op == OP_LD) || (op == OP_ST) || (op == OP_JMP) ||
             (op == OP_BEQ) || (op == OP_BNE) || (op == OP_LDR);
   endfunction

   function automatic logic is_muldiv(input logic [5:0] op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == 6'h32) || (op == 6'h33);
   endfunction

   // Single-cycle control word; all zero for illegal opcodes.
   function automatic ctl_t decode(input logic [5:0] op, input logic z);
      ctl_t c;
      c = '0;
      if (is_alu_op(op)) begin
         c.alufn = {2'b00, op[3:0]};
         c.bsel  = op[4];
         c.wdsel = WDSEL_ALU;
         c.werf  = 1'b1;
      end else begin
         case (op)
            OP_LD: begin
               c.alufn = ALU_ADD; c.bsel = 1'b1; c.moe = 1'b1;
               c.wdsel = WDSEL_MEM; c.werf = 1'b1;
            end
            OP_ST: begin
               c.alufn = ALU_ADD; c.bsel = 1'b1; c.mwr = 1'b1; c.ra2sel = 1'b1;
            end
            OP_JMP: begin
               c.pcsel = PCSEL_JMP; c.wdsel = WDSEL_PC; c.werf = 1'b1;
            end
            OP_BEQ: begin
               c.pcsel = {2'b00, z}; c.wdsel = WDSEL_PC; c.werf = 1'b1;
            end
            OP_BNE: begin
               c.pcsel = {2'b00, ~z}; c.wdsel = WDSEL_PC; c.werf = 1'b1;
            end
            OP_LDR: begin
               c.alufn = ALU_A; c.asel = 1'b1; c.moe = 1'b1;
               c.wdsel = WDSEL_MEM; c.werf = 1'b1;
            end
            default: ;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/ctl_mc_irq_arb.sv
// ctl_mc_irq_arb: latched interrupt requests with fixed-priority selection.
//   clk, reset   : clock, synchronous active-high reset
//   irq          : level requests; any high line sets its pending bit
//   take         : the control FSM is taking an interrupt this cycle
//   pending_any  : at least one request is pending
//   ack          : one-hot acknowledge of the lowest pending index while take = 1
module ctl_mc_irq_arb #(
   parameter int unsigned NUM_IRQ = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               take,
   output logic               pending_any,
   output logic [NUM_IRQ-1:0] ack
);

   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] lowest;

   // Two's-complement trick isolates the lowest set bit (highest priority).
   assign lowest      = pending_q & (~pending_q + NUM_IRQ'(1));
   assign pending_any = |pending_q;

   always_comb begin
      ack       = take ? lowest : '0;
      // A line still high in its ack cycle re-arms its pending bit.
      pending_d = (pending_q & ~ack) | irq;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

endmodule

// File: rtl/ctl_mc.sv
// ctl_mc: multi-cycle control unit for the Beta-style RISC core.
//   Inputs : clk, reset (sync, active-high), op, z, supervisor, irq,
//            alu_done, mem_ready
//   Outputs: datapath control word (alufn, asel, bsel, moe, mwr, pcsel, ra2sel,
//            wasel, wdsel, werf), pc_en, alu_start, irq_ack, illop_cnt
// The control word is combinational from state and inputs so that memory and
// ALU completions retire in the same cycle they are signalled.
module ctl_mc
   import ctl_mc_pkg::*;
#(
   parameter int unsigned NUM_IRQ   = 4,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned MULDIV_MC = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic               z,
   input  logic               supervisor,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               alu_done,
   input  logic               mem_ready,
   output logic [5:0]         alufn,
   output logic               asel,
   output logic               bsel,
   output logic               moe,
   output logic               mwr,
   output logic [2:0]         pcsel,
   output logic               ra2sel,
   output logic               wasel,
   output logic [1:0]         wdsel,
   output logic               werf,
   output logic               pc_en,
   output logic               alu_start,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic [CNT_W-1:0]   illop_cnt
);

   state_e           state_q, state_d;
   logic [5:0]       op_q, op_d;   // opcode that entered a wait state
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctl_t             dec_cur, dec_held;
   logic             irq_any, irq_take;

   assign dec_cur   = decode(op, z);
   assign dec_held  = decode(op_q, 1'b0);
   assign irq_take  = !reset && (state_q == S_EXEC) && irq_any && !supervisor;
   assign illop_cnt = cnt_q;

   ctl_mc_irq_arb #(
      .NUM_IRQ(NUM_IRQ)
   ) u_irq_arb (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .take       (irq_take),
      .pending_any(irq_any),
      .ack        (irq_ack)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      alufn     = '0;
      asel      = 1'b0;
      bsel      = 1'b0;
      moe       = 1'b0;
      mwr       = 1'b0;
      pcsel     = PCSEL_INC;
      ra2sel    = 1'b0;
      wasel     = 1'b0;
      wdsel     = WDSEL_PC;
      werf      = 1'b0;
      pc_en     = 1'b0;
      alu_start = 1'b0;

      // Outputs stay quiet while reset is high, whatever state was interrupted.
      if (!reset) begin
         unique case (state_q)
            S_RESET: state_d = S_EXEC;

            S_EXEC: begin
               op_d = op;
               if (irq_take) begin
                  pcsel = PCSEL_XADR;
                  wasel = 1'b1;
                  werf  = 1'b1;
                  pc_en = 1'b1;
               end else if (!is_legal(op)) begin
                  pcsel = PCSEL_ILLOP;
                  wasel = 1'b1;
                  werf  = 1'b1;
                  pc_en = 1'b1;
                  if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  {alufn, asel, bsel, moe, mwr, pcsel, ra2sel, wasel, wdsel, werf} = dec_cur;
                  if ((MULDIV_MC != 0) && is_muldiv(op)) begin
                     werf      = 1'b0;
                     alu_start = 1'b1;
                     state_d   = S_ALU_WAIT;
                  end else if ((dec_cur.moe || dec_cur.mwr) && !mem_ready) begin
                     werf    = 1'b0;
                     state_d = S_MEM_WAIT;
                  end else begin
                     pc_en = 1'b1;
                  end
               end
            end

            S_ALU_WAIT: begin
               alufn = dec_held.alufn;
               asel  = dec_held.asel;
               bsel  = dec_held.bsel;
               if (alu_done) begin
                  wdsel   = WDSEL_ALU;
                  werf    = 1'b1;
                  pc_en   = 1'b1;
                  state_d = S_EXEC;
               end
            end

            S_MEM_WAIT: begin
               {alufn, asel, bsel, moe, mwr, pcsel, ra2sel, wasel, wdsel, werf} = dec_held;
               if (mem_ready) begin
                  pc_en   = 1'b1;
                  state_d = S_EXEC;
               end else begin
                  werf = 1'b0;
               end
            end

            default: state_d = S_RESET;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RESET;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ctl_mc.sv
// tb_ctl_mc: directed self-checking bench for ctl_mc (NUM_IRQ=4, CNT_W=8,
// MULDIV_MC=1). Inputs change just after a rising edge; outputs are compared
// 1 ns later, well away from the next edge.
module tb_ctl_mc;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic       z;
   logic       supervisor;
   logic [3:0] irq;
   logic       alu_done;
   logic       mem_ready;
   logic [5:0] alufn;
   logic       asel, bsel, moe, mwr, ra2sel, wasel, werf, pc_en, alu_start;
   logic [2:0] pcsel;
   logic [1:0] wdsel;
   logic [3:0] irq_ack;
   logic [7:0] illop_cnt;
   logic [19:0] cw_obs;

   int checks   = 0;
   int failures = 0;

   ctl_mc #(
      .NUM_IRQ  (4),
      .CNT_W    (8),
      .MULDIV_MC(1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .z         (z),
      .supervisor(supervisor),
      .irq       (irq),
      .alu_done  (alu_done),
      .mem_ready (mem_ready),
      .alufn     (alufn),
      .asel      (asel),
      .bsel      (bsel),
      .moe       (moe),
      .mwr       (mwr),
      .pcsel     (pcsel),
      .ra2sel    (ra2sel),
      .wasel     (wasel),
      .wdsel     (wdsel),
      .werf      (werf),
      .pc_en     (pc_en),
      .alu_start (alu_start),
      .irq_ack   (irq_ack),
      .illop_cnt (illop_cnt)
   );

   assign cw_obs = {alufn, asel, bsel, moe, mwr, pcsel, ra2sel, wasel, wdsel, werf, pc_en,
                    alu_start};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] mk(input logic [5:0] fn, input logic a, input logic b,
                                      input logic m, input logic w, input logic [2:0] pc,
                                      input logic r2, input logic wa, input logic [1:0] wd,
                                      input logic we, input logic pe, input logic st);
      return {fn, a, b, m, w, pc, r2, wa, wd, we, pe, st};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [19:0] cw_zero, cw_add, cw_illop, cw_xadr, cw_ld_wait, cw_ld_done;
      cw_zero    = '0;
      cw_add     = mk(6'h00, 0, 0, 0, 0, 3'd0, 0, 0, 2'd1, 1, 1, 0);
      cw_illop   = mk(6'h00, 0, 0, 0, 0, 3'd3, 0, 1, 2'd0, 1, 1, 0);
      cw_xadr    = mk(6'h00, 0, 0, 0, 0, 3'd4, 0, 1, 2'd0, 1, 1, 0);
      cw_ld_wait = mk(6'h00, 0, 1, 1, 0, 3'd0, 0, 0, 2'd2, 0, 0, 0);
      cw_ld_done = mk(6'h00, 0, 1, 1, 0, 3'd0, 0, 0, 2'd2, 1, 1, 0);

      reset = 1'b1; op = 6'h20; z = 1'b0; supervisor = 1'b0; irq = '0;
      alu_done = 1'b0; mem_ready = 1'b0;

      // Reset held three cycles: everything zero.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_cw", 32'(cw_obs), 32'(cw_zero));
         chk("rst_ack_cnt", 32'({irq_ack, illop_cnt}), 32'(0));
      end

      // First cycle after release: still S_RESET, no pc_en.
      reset = 1'b0; #1;
      chk("post_rst_cw", 32'(cw_obs), 32'(cw_zero));
      tick();
      chk("add", 32'(cw_obs), 32'(cw_add));

      op = 6'h30; #1;
      chk("addc", 32'(cw_obs), 32'(mk(6'h00, 0, 1, 0, 0, 3'd0, 0, 0, 2'd1, 1, 1, 0)));
      op = 6'h1C; z = 1'b1; #1;
      chk("beq_taken", 32'(cw_obs), 32'(mk(6'h00, 0, 0, 0, 0, 3'd1, 0, 0, 2'd0, 1, 1, 0)));
      op = 6'h1D; #1;
      chk("bne_not_taken", 32'(cw_obs), 32'(mk(6'h00, 0, 0, 0, 0, 3'd0, 0, 0, 2'd0, 1, 1, 0)));
      op = 6'h1B; z = 1'b0; #1;
      chk("jmp", 32'(cw_obs), 32'(mk(6'h00, 0, 0, 0, 0, 3'd2, 0, 0, 2'd0, 1, 1, 0)));
      op = 6'h19; mem_ready = 1'b1; #1;
      chk("st_ready", 32'(cw_obs), 32'(mk(6'h00, 0, 1, 0, 1, 3'd0, 1, 0, 2'd0, 0, 1, 0)));
      op = 6'h1F; #1;
      chk("ldr_ready", 32'(cw_obs), 32'(mk(6'h1A, 1, 0, 1, 0, 3'd0, 0, 0, 2'd2, 1, 1, 0)));
      tick();

      // MUL: start pulse, four silent wait cycles, done in the fifth.
      op = 6'h22; mem_ready = 1'b0; #1;
      chk("mul_issue", 32'(cw_obs), 32'(mk(6'h02, 0, 0, 0, 0, 3'd0, 0, 0, 2'd1, 0, 0, 1)));
      tick();
      op = 6'h20;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("mul_wait", 32'(cw_obs), 32'(mk(6'h02, 0, 0, 0, 0, 3'd0, 0, 0, 2'd0, 0, 0, 0)));
         tick();
      end
      alu_done = 1'b1; #1;
      chk("mul_done", 32'(cw_obs), 32'(mk(6'h02, 0, 0, 0, 0, 3'd0, 0, 0, 2'd1, 1, 1, 0)));
      tick();
      alu_done = 1'b0; #1;
      chk("after_mul_add", 32'(cw_obs), 32'(cw_add));
      tick();

      // LD with memory not ready for two cycles.
      op = 6'h18; #1;
      chk("ld_issue", 32'(cw_obs), 32'(cw_ld_wait));
      tick();
      op = 6'h20; #1;
      chk("ld_wait", 32'(cw_obs), 32'(cw_ld_wait));
      tick();
      mem_ready = 1'b1; #1;
      chk("ld_done", 32'(cw_obs), 32'(cw_ld_done));
      tick();
      mem_ready = 1'b0;

      // DIV with interrupts raised mid-wait.
      op = 6'h23; #1;
      chk("div_issue", 32'(cw_obs), 32'(mk(6'h03, 0, 0, 0, 0, 3'd0, 0, 0, 2'd1, 0, 0, 1)));
      tick();
      irq = 4'b0110; op = 6'h20;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("div_wait_noack", 32'({irq_ack, pc_en}), 32'(0));
         tick();
      end
      alu_done = 1'b1; #1;
      chk("div_done_noack", 32'({irq_ack, pc_en, werf}), 32'({4'b0000, 2'b11}));
      tick();
      alu_done = 1'b0;
      irq = 4'b0100; #1;   // line 1 drops when acknowledged, line 2 stays up
      chk("irq1_cw", 32'(cw_obs), 32'(cw_xadr));
      chk("irq1_ack", 32'(irq_ack), 32'(4'b0010));
      tick();
      chk("irq2_ack", 32'(irq_ack), 32'(4'b0100));
      chk("irq2_cw", 32'(cw_obs), 32'(cw_xadr));
      tick();
      supervisor = 1'b1; irq = 4'b0000; #1;
      chk("sup_noack", 32'(irq_ack), 32'(0));
      chk("sup_add", 32'(cw_obs), 32'(cw_add));
      tick();
      chk("sup_noack2", 32'(irq_ack), 32'(0));
      tick();
      supervisor = 1'b0; #1;
      chk("unmask_ack", 32'(irq_ack), 32'(4'b0100));
      tick();
      chk("ack_clear", 32'(irq_ack), 32'(0));
      chk("ack_clear_add", 32'(cw_obs), 32'(cw_add));
      tick();

      // 300 illegal opcodes; counter saturates at 255.
      op = 6'h3F;
      for (int i = 0; i < 300; i++) begin
         #1;
         chk("illop_cw", 32'(cw_obs), 32'(cw_illop));
         chk("illop_cnt", 32'(illop_cnt), (i < 255) ? i : 255);
         tick();
      end
      chk("illop_sat", 32'(illop_cnt), 32'(255));

      // Reset during S_MEM_WAIT with an interrupt pending.
      op = 6'h18; irq = 4'b0001; #1;
      chk("ld2_issue", 32'(cw_obs), 32'(cw_ld_wait));
      tick();
      irq = 4'b0000; reset = 1'b1; #1;
      chk("rst_mem_cw", 32'(cw_obs), 32'(cw_zero));
      tick();
      chk("rst_mem_cnt", 32'({irq_ack, illop_cnt}), 32'(0));
      reset = 1'b0; mem_ready = 1'b1; #1;
      chk("late_ready", 32'(cw_obs), 32'(cw_zero));
      tick();
      mem_ready = 1'b0; op = 6'h20; #1;
      chk("rst_irq_cleared", 32'(irq_ack), 32'(0));
      chk("rst_mem_add", 32'(cw_obs), 32'(cw_add));
      tick();

      // Reset during S_ALU_WAIT.
      op = 6'h22; #1;
      chk("mul2_issue", 32'(alu_start), 32'(1));
      tick();
      reset = 1'b1; #1;
      chk("rst_alu_cw", 32'(cw_obs), 32'(cw_zero));
      tick();
      reset = 1'b0; alu_done = 1'b1; #1;
      chk("late_done", 32'(cw_obs), 32'(cw_zero));
      tick();
      alu_done = 1'b0; op = 6'h20; #1;
      chk("rst_alu_add", 32'(cw_obs), 32'(cw_add));
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
